// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM states, command-word layout
// and default widths.
package adc_pkg;

  localparam int CH_W_DEF      = 2;
  localparam int DATA_W_DEF    = 16;
  localparam int ADC_CMD_START = DATA_W_DEF - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_SCAN_END
  } adc_state_e;

  // Command frame: start bit, channel index just below it, remaining bits zero.
  function automatic logic [DATA_W_DEF-1:0] build_cmd(input logic [CH_W_DEF-1:0] ch);
    logic [DATA_W_DEF-1:0] w;
    w = '0;
    w[ADC_CMD_START] = 1'b1;
    w[ADC_CMD_START-1 -: CH_W_DEF] = ch;
    return w;
  endfunction

endpackage

// File: rtl/adc_ch_picker.sv
// Holds the channels still to be converted in the current scan and presents the lowest
// one, plus flags telling whether any remain and whether it is the final one.
module adc_ch_picker import adc_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NUM_CH-1:0] mask_in,
  input  logic              advance,
  output logic [CH_W-1:0]   cur_ch,
  output logic              valid,
  output logic              last
);

  logic [NUM_CH-1:0] rem_q, rem_d, rem_next;

  always_comb begin
    cur_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) cur_ch = CH_W'(i);
    end
  end

  assign rem_next = rem_q & ~(NUM_CH'(1) << cur_ch);
  assign valid    = |rem_q;
  assign last     = valid && (rem_next == '0);

  always_comb begin
    rem_d = rem_q;
    if (load)         rem_d = mask_in;
    else if (advance) rem_d = rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Drives the shared ADC SPI engine: trigger-driven channel scans with priority over CPU
// one-shot conversions. Define ADC_OVERSAMPLE_EN to average 2^OS_LOG2 frames per scan channel.
module adc_scan_sequencer import adc_pkg::*; #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = CH_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = 4
`ifdef ADC_OVERSAMPLE_EN
  ,
  parameter int OS_LOG2    = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              trig,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              cpu_req,
  input  logic [CH_W-1:0]   cpu_ch,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_tx,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rx,
  output logic              res_we,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_data,
  output logic              scan_done,
  output logic              overrun,
  output logic              busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  adc_state_e        state_q, state_d;
  logic              scan_mode_q, scan_mode_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CH_W-1:0]   cpu_ch_q, cpu_ch_d;
  logic              spi_start_q, spi_start_d;
  logic [DATA_W-1:0] spi_tx_q, spi_tx_d;
  logic              res_we_q, res_we_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;

  logic              trig_ok;
  logic              pick_load, pick_adv, pick_valid, pick_last;
  logic [CH_W-1:0]   pick_ch;

`ifdef ADC_OVERSAMPLE_EN
  localparam int ACC_W = DATA_W + OS_LOG2;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
  logic [OS_LOG2-1:0] os_cnt_q, os_cnt_d;

  assign acc_sum = acc_q + ACC_W'(spi_rx);
`endif

  assign trig_ok = trig & enable;

  adc_ch_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_picker (
    .clk     (clk),
    .rst     (rst),
    .load    (pick_load),
    .mask_in (ch_mask),
    .advance (pick_adv),
    .cur_ch  (pick_ch),
    .valid   (pick_valid),
    .last    (pick_last)
  );

  always_comb begin
    state_d     = state_q;
    scan_mode_d = scan_mode_q;
    pend_d      = pend_q & enable;  // disabling discards a queued trigger
    ovr_d       = ovr_q;
    gap_cnt_d   = gap_cnt_q;
    cpu_ch_d    = cpu_ch_q;
    spi_start_d = 1'b0;
    spi_tx_d    = spi_tx_q;
    res_we_d    = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    cpu_ack_d   = 1'b0;
    cpu_data_d  = cpu_data_q;
    pick_load   = 1'b0;
    pick_adv    = 1'b0;
`ifdef ADC_OVERSAMPLE_EN
    acc_d       = acc_q;
    os_cnt_d    = os_cnt_q;
`endif

    if (trig_ok && state_q != ST_IDLE) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (trig_ok || (pend_q && enable)) begin
          pick_load   = 1'b1;
          scan_mode_d = 1'b1;
          // a fresh trigger coinciding with a queued one stays queued behind it
          pend_d      = pend_q & trig_ok;
          state_d     = (ch_mask == '0) ? ST_SCAN_END : ST_ISSUE;
        end else if (cpu_req) begin
          scan_mode_d = 1'b0;
          cpu_ch_d    = cpu_ch;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_tx_d    = build_cmd(scan_mode_q ? pick_ch : cpu_ch_q);
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (spi_done) begin
          if (scan_mode_q) begin
`ifdef ADC_OVERSAMPLE_EN
            if (os_cnt_q == '1) begin
              res_we_d   = 1'b1;
              res_ch_d   = pick_ch;
              res_data_d = DATA_W'(acc_sum >> OS_LOG2);
              acc_d      = '0;
              os_cnt_d   = '0;
              pick_adv   = 1'b1;
              state_d    = pick_last ? ST_SCAN_END : ST_GAP;
            end else begin
              acc_d      = acc_sum;
              os_cnt_d   = os_cnt_q + 1'b1;
              state_d    = ST_GAP;
            end
`else
            res_we_d   = 1'b1;
            res_ch_d   = pick_ch;
            res_data_d = spi_rx;
            pick_adv   = 1'b1;
            state_d    = pick_last ? ST_SCAN_END : ST_GAP;
`endif
          end else begin
            cpu_ack_d  = 1'b1;
            cpu_data_d = spi_rx;
            state_d    = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = (scan_mode_q && pick_valid) ? ST_ISSUE : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_SCAN_END: state_d = ST_GAP;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scan_mode_q <= 1'b0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      gap_cnt_q   <= '0;
      spi_start_q <= 1'b0;
      spi_tx_q    <= '0;
      res_we_q    <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      scan_mode_q <= scan_mode_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_start_q <= spi_start_d;
      spi_tx_q    <= spi_tx_d;
      res_we_q    <= res_we_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_data_q  <= cpu_data_d;
    end
  end

  always_ff @(posedge clk) begin
    cpu_ch_q <= cpu_ch_d;
  end

`ifdef ADC_OVERSAMPLE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      os_cnt_q <= '0;
    end else begin
      acc_q    <= acc_d;
      os_cnt_q <= os_cnt_d;
    end
  end
`endif

  assign cpu_ack   = cpu_ack_q;
  assign cpu_data  = cpu_data_q;
  assign spi_start = spi_start_q;
  assign spi_tx    = spi_tx_q;
  assign res_we    = res_we_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign scan_done = (state_q == ST_SCAN_END);
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
